// File: rtl/mult_seq_pkg.sv
// Shared constants for the picoMIPS fixed-point datapath: default operand
// width and the sequential multiplier's FSM encoding.
package mult_seq_pkg;

    // Datapath width; also used to size downstream register instances.
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mult_state_t;

endpackage : mult_seq_pkg

// File: rtl/mult_sat.sv
// Combinational fixed-point narrowing: arithmetic right shift of a signed
// 2*WIDTH product by WIDTH-1 (floor rounding), then clamp to WIDTH bits.
module mult_sat
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_full,
    output logic [WIDTH-1:0]   o_sat
);

    logic [2*WIDTH-1:0] w_shifted;
    logic [WIDTH:0]     w_hi;
    logic               w_in_range;

    assign w_shifted  = $signed(i_full) >>> (WIDTH - 1);
    // Result fits only if every bit above the kept field repeats its sign.
    assign w_hi       = w_shifted[2*WIDTH-1:WIDTH-1];
    assign w_in_range = (&w_hi) || (~|w_hi);

    // Pass the shifted value through, or clamp toward the sign of the overflow.
    always_comb begin
        // NOTE: default assignment first so every path drives o_sat; no latch.
        o_sat = w_shifted[WIDTH-1:0];
        if (!w_in_range) begin
            o_sat = w_shifted[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule : mult_sat

// File: rtl/mult_seq.sv
// Iterative radix-2 signed shift-add multiplier: product = sat((a*b) >>> (WIDTH-1)),
// one multiplier bit per cycle, LSB first, WIDTH cycles from accept to done.
module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    mult_state_t        r_state;
    mult_state_t        w_state_next;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_product;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_sat;
    logic               w_last;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Accumulate one partial product; the multiplier MSB carries negative weight.
    always_comb begin
        w_acc_next = r_acc;
        if (r_mplier[0]) begin
            w_acc_next = w_last ? (r_acc - r_mcand) : (r_acc + r_mcand);
        end
    end

    mult_sat #(
        .WIDTH (WIDTH)
    ) u_mult_sat (
        .i_full (w_acc_next),
        .o_sat  (w_sat)
    );

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start is honoured only outside RUN.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: w_state_next = start ? ST_RUN : ST_IDLE;
            ST_RUN:  w_state_next = w_last ? ST_DONE : ST_RUN;
            ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        busy = (r_state == ST_RUN);
        done = (r_state == ST_DONE);
    end

    // Datapath: capture operands on accept, iterate in RUN, load result on the last step.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (r_state == ST_RUN) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_product <= w_sat;
            end
        end else if (start) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
            r_mplier <= b;
            r_cnt    <= '0;
        end
    end

    assign product = r_product;

endmodule : mult_seq

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed vector table, held-start
// throughput sequence, mid-RUN reset, and randomised operand sweep.
module tb_mult_seq;

    localparam int W = 8;

    logic                clk;
    logic                n_reset;
    logic                start;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic                busy;
    logic                done;
    logic signed [W-1:0] product;

    // Model of the downstream register fed by product/done.
    logic signed [W-1:0] reg_q;

    int n_checks;
    int n_errors;
    int exp_q[$];

    typedef struct {
        logic signed [W-1:0] a;
        logic signed [W-1:0] b;
        int                  exp;
    } vec_t;

    vec_t vecs[10];

    mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            reg_q <= '0;
        end else if (done) begin
            reg_q <= product;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Independent reference: floor((a*b)/2^(W-1)) clamped to W-bit signed.
    function automatic int ref_mult(input int ra, input int rb);
        int p;
        p = (ra * rb) >>> (W - 1);
        if (p > 127) p = 127;
        if (p < -128) p = -128;
        return p;
    endfunction

    // Scoreboard: every done pops the oldest expected result.
    always @(negedge clk) begin
        if (n_reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("product", int'(product), exp_q.pop_front());
            end
        end
    end

    // One isolated multiply; detailed mode checks the busy/done cycle timing.
    task automatic do_op(input logic signed [W-1:0] ta, input logic signed [W-1:0] tb_,
                         input int exp, input bit detailed);
        int n;
        @(negedge clk);
        a = ta;
        b = tb_;
        start = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        a = ~ta;
        b = ~tb_;
        if (detailed) begin
            for (int k = 0; k < W; k++) begin
                check("busy_in_run", int'(busy), 1);
                check("done_in_run", int'(done), 0);
                @(negedge clk);
            end
            check("done_strobe", int'(done), 1);
            check("busy_at_done", int'(busy), 0);
        end else begin
            n = 0;
            while (!done && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!done) check("done_timeout", 0, 1);
        end
        @(negedge clk);
        check("done_falls", int'(done), 0);
        check("downstream_reg", int'(reg_q), exp);
    endtask

    initial begin
        logic signed [W-1:0] corners[6];
        logic signed [W-1:0] ra;
        logic signed [W-1:0] rb;
        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{8'sd100,  8'sd64,   50};
        vecs[1] = '{-8'sd3,   8'sd64,   -2};
        vecs[2] = '{-8'sd100, 8'sd64,   -50};
        vecs[3] = '{-8'sd128, -8'sd128, 127};
        vecs[4] = '{8'sd127,  -8'sd128, -127};
        vecs[5] = '{8'sd0,    -8'sd128, 0};
        vecs[6] = '{8'sd1,    -8'sd1,   -1};
        vecs[7] = '{8'sd127,  8'sd127,  126};
        vecs[8] = '{-8'sd1,   -8'sd1,   0};
        vecs[9] = '{8'sd64,   -8'sd128, -64};

        n_reset = 1'b0;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_product", int'(product), 0);
        n_reset = 1'b1;
        @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Directed table; first entry gets full timing checks.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp, i == 0);
        end

        // start held high, operands changing every cycle: accepts every W+1 cycles.
        for (int cyc = 0; cyc < 3 * (W + 1); cyc++) begin
            @(negedge clk);
            if (cyc > 0) check("held_done_cadence", int'(done), int'(cyc % (W + 1) == 0));
            ra = W'($urandom);
            rb = W'($urandom);
            a = ra;
            b = rb;
            start = 1'b1;
            if (cyc % (W + 1) == 0) exp_q.push_back(ref_mult(int'(ra), int'(rb)));
        end
        @(negedge clk);
        check("held_last_done", int'(done), 1);
        start = 1'b0;
        @(negedge clk);
        check("held_idle", int'(done), 0);

        // Ensure product is non-zero, then reset in the middle of RUN.
        do_op(8'sd50, 8'sd64, 25, 1'b0);
        @(negedge clk);
        a = 8'sd90;
        b = 8'sd64;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 n_reset = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_product", int'(product), 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("no_done_after_rst", int'(done), 0);
        end
        check("product_after_rst", int'(product), 0);
        do_op(8'sd10, -8'sd64, -5, 1'b1);

        // Randomised sweep: corner pairs first, then random operands.
        corners = '{-8'sd128, -8'sd127, -8'sd1, 8'sd0, 8'sd1, 8'sd127};
        for (int i = 0; i < 1000; i++) begin
            if (i < 36) begin
                ra = corners[i / 6];
                rb = corners[i % 6];
            end else begin
                ra = W'($urandom);
                rb = W'($urandom);
            end
            do_op(ra, rb, ref_mult(int'(ra), int'(rb)), 1'b0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mult_seq
